prbs6_checker: RTL and testbench
================================

# prbs6_checker

Serial receiver-side checker for the 6-bit maximal-length LFSR pattern (x^6 + x^5 + 1, period 63) produced by the team's LFSR6 generator. It seeds a local predictor from the incoming bit stream and declares lock after a run of correct predictions. Once locked, it flywheels on its own prediction and flags every bit error. It sits between a board input pin (or loopback) and the status/LED logic of a PRBS link test.

## Interface
- LOCK_CNT, 8: consecutive correct predictions after seeding required to declare lock (1..255)
- LOSS_THRESH, 4: errors within one window that force loss of lock (1..WIN)
- WIN, 32: window length in valid bits for loss-of-lock counting (power of two, 8..256)
- CLK  in  1  sole clock, rising edge
- RESETN  in  1  asynchronous, active-low reset
- I  in  1  received serial bit
- VALID  in  1  I is sampled on this CLK edge when high; bits with VALID low are ignored entirely
- LOCK  out  1  checker locked
- ERR  out  1  one-cycle pulse: mismatch detected on a locked bit
- ERR_CNT  out  16  saturating count of locked-bit errors (see Configuration)

## Operation
- Sequence rule: b[n] = b[n-5] XOR b[n-6]. History register h[5:0]; new bit enters h[0], h[5] is the oldest bit; prediction p = h[4] XOR h[5].
- All state advances only on valid bits.
- FSM states: SEED, VERIFY, LOCKED.
- SEED: shift I into h and count 0..6. At 6 bits, move to VERIFY if h != 0. If h == 0 (lock-up pattern, not in the sequence), stay in SEED with the count held at 6 and continue shifting until h != 0.
- VERIFY: compare I to p and shift I into h.
  - Match: increment the good count. The LOCK_CNT-th consecutive match moves to LOCKED.
  - Mismatch: return to SEED with the bit count cleared. ERR does not pulse.
- LOCKED: compare I to p and shift p, not I, into h (flywheel, so there is no error multiplication).
  - Mismatch: pulse ERR, increment the window error count, increment ERR_CNT (saturates at 0xFFFF).
  - The window counter counts valid bits. On the WIN-th bit, the window error count clears.
  - Same bit is both an error and the window end: count the error first, check the threshold, then clear the window.
  - Window error count reaches LOSS_THRESH: go to SEED, clear all counters except ERR_CNT.
- ERR_CNT is cleared only by reset.

## Timing
- Reset values: LOCK=0, ERR=0, ERR_CNT=0, h=0, state SEED, all counters 0.
- All outputs are registered.
  - LOCK rises the cycle after the edge that samples the LOCK_CNT-th good bit.
  - LOCK falls the cycle after the edge that samples the threshold-reaching error.
  - ERR is high for exactly the cycle after the sampling edge of the errored bit.
- Minimum time to lock from reset on a clean stream: 6 + LOCK_CNT valid bits.
- Back-to-back VALID (every cycle) is supported at full rate.
- Gaps of any length hold all state.
- RESETN asserted mid-operation returns to reset values immediately, with no clock edge required. The first valid bit after deassertion is treated as seed bit 0.

## Configuration
- PRBS6_CHK_ERRCNT_EN defined: the 16-bit saturating ERR_CNT register is built as described.
- PRBS6_CHK_ERRCNT_EN undefined: no counter is built and ERR_CNT is tied to 0. ERR, LOCK and the FSM are unchanged.

## Structure
- Package prbs6_pkg holds:
  - state enum (SEED, VERIFY, LOCKED)
  - PRBS_W = 6
  - tap index constants TAP_A = 4, TAP_B = 5
  - ERR_CNT_W = 16
- Sub-module prbs6_predictor holds:
  - the 6-bit history register with load-select (I or p) and shift enable
  - combinational prediction output p
- The top module holds the FSM, counters and outputs.

## Test plan
- Clean stream: generator sequence seeded 000001, VALID every cycle -> LOCK rises after exactly 14 valid bits, ERR never pulses, ERR_CNT stays 0 over 1000 bits.
- Single flipped bit at locked bit 20 -> one ERR pulse, ERR_CNT=1, LOCK stays 1, subsequent bits error-free (flywheel proven).
- Four flipped bits within one 32-bit window -> LOCK falls the cycle after the 4th error. Clean stream afterward -> relock after 14 more valid bits. ERR_CNT=4.
- Three errors at the end of one window and one at the start of the next -> LOCK stays 1. Error on exactly the 32nd window bit is counted before the window clears.
- All-zero input for 20 bits, then the clean stream -> no LOCK during the zeros, state stays SEED, lock achieved after the stream starts.
- VALID toggling 1-of-3 cycles with RESETN pulsed low mid-VERIFY -> outputs at reset values asynchronously. Lock timing then counts valid bits only.
- With the macro undefined, repeat the error scenario -> ERR pulses identical, ERR_CNT constant 0.

Source files
------------

// File: rtl/prbs6_pkg.sv
// Shared types and constants for the PRBS6 (x^6 + x^5 + 1) receive checker.
package prbs6_pkg;

   localparam int unsigned PRBS_W    = 6;
   localparam int unsigned TAP_A     = 4;
   localparam int unsigned TAP_B     = 5;
   localparam int unsigned ERR_CNT_W = 16;

   typedef enum logic [1:0] {
      StSeed   = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } state_e;

   // Next sequence bit from the history: b[n] = b[n-5] ^ b[n-6].
   function automatic logic prbs_pred(input logic [PRBS_W-1:0] hist);
      return hist[TAP_A] ^ hist[TAP_B];
   endfunction

endpackage

// File: rtl/prbs6_predictor.sv
// PRBS6 history register with selectable load (received bit or own prediction).
module prbs6_predictor
   import prbs6_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_shift,
   input  logic              i_sel_pred,
   input  logic              i_data,
   output logic [PRBS_W-1:0] o_hist,
   output logic              o_pred
);

   logic [PRBS_W-1:0] r_hist;
   logic              w_pred;
   logic              w_in;

   assign w_pred = prbs_pred(r_hist);
   assign w_in   = i_sel_pred ? w_pred : i_data;

   // Newest bit enters bit 0; bit PRBS_W-1 is the oldest.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hist <= '0;
      end else if (i_shift) begin
         r_hist <= {r_hist[PRBS_W-2:0], w_in};
      end
   end

   assign o_hist = r_hist;
   assign o_pred = w_pred;

endmodule

// File: rtl/prbs6_checker.sv
// PRBS6 lock/error checker: seed, verify, then flywheel and count bit errors.
// Define PRBS6_CHK_ERRCNT_EN to build the 16-bit saturating error counter.
module prbs6_checker
   import prbs6_pkg::*;
#(
   parameter int unsigned LOCK_CNT    = 8,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned WIN         = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_data,
   input  logic                 i_valid,
   output logic                 o_lock,
   output logic                 o_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   localparam int unsigned       WIN_W     = $clog2(WIN);
   localparam int unsigned       WERR_W    = $clog2(WIN + 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
   localparam logic [WERR_W-1:0] THRESH    = WERR_W'(LOSS_THRESH);
   localparam logic [7:0]        GOOD_LAST = 8'(LOCK_CNT - 1);
   localparam logic [2:0]        SEED_FULL = 3'(PRBS_W);

   state_e             r_state;
   logic [2:0]         r_seed_cnt;
   logic [7:0]         r_good_cnt;
   logic [WIN_W-1:0]   r_win_cnt;
   logic [WERR_W-1:0]  r_win_err;
   logic               r_lock;
   logic               r_err;

   logic [PRBS_W-1:0]  w_hist;
   logic [PRBS_W-1:0]  w_hist_next;
   logic               w_pred;
   logic               w_mismatch;
   logic               w_err_hit;
   logic [2:0]         w_seed_next;
   logic [WERR_W-1:0]  w_win_err_inc;

   prbs6_predictor u_predictor (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_shift    (i_valid),
      .i_sel_pred (r_state == StLocked),
      .i_data     (i_data),
      .o_hist     (w_hist),
      .o_pred     (w_pred)
   );

   // History as it will be after shifting the received bit (seed-phase view).
   assign w_hist_next   = {w_hist[PRBS_W-2:0], i_data};
   assign w_mismatch    = (i_data != w_pred);
   assign w_err_hit     = i_valid && (r_state == StLocked) && w_mismatch;
   assign w_seed_next   = (r_seed_cnt == SEED_FULL) ? SEED_FULL : r_seed_cnt + 3'd1;
   assign w_win_err_inc = r_win_err + WERR_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StSeed;
         r_seed_cnt <= '0;
         r_good_cnt <= '0;
         r_win_cnt  <= '0;
         r_win_err  <= '0;
         r_lock     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_err_hit;
         if (i_valid) begin
            case (r_state)
               StSeed: begin
                  r_seed_cnt <= w_seed_next;
                  // All-zero history is the lock-up pattern; keep shifting until it clears.
                  if ((w_seed_next == SEED_FULL) && (w_hist_next != '0)) begin
                     r_state    <= StVerify;
                     r_good_cnt <= '0;
                  end
               end
               StVerify: begin
                  if (w_mismatch) begin
                     r_state    <= StSeed;
                     r_seed_cnt <= '0;
                     r_good_cnt <= '0;
                  end else if (r_good_cnt == GOOD_LAST) begin
                     r_state    <= StLocked;
                     r_lock     <= 1'b1;
                     r_good_cnt <= '0;
                     r_win_cnt  <= '0;
                     r_win_err  <= '0;
                  end else begin
                     r_good_cnt <= r_good_cnt + 8'd1;
                  end
               end
               StLocked: begin
                  // Error is counted and thresholded before the window end clears it.
                  if (w_mismatch && (w_win_err_inc >= THRESH)) begin
                     r_state    <= StSeed;
                     r_lock     <= 1'b0;
                     r_seed_cnt <= '0;
                     r_good_cnt <= '0;
                     r_win_cnt  <= '0;
                     r_win_err  <= '0;
                  end else if (r_win_cnt == WIN_LAST) begin
                     r_win_cnt <= '0;
                     r_win_err <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + WIN_W'(1);
                     if (w_mismatch) begin
                        r_win_err <= w_win_err_inc;
                     end
                  end
               end
               default: begin
                  r_state <= StSeed;
                  r_lock  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PRBS6_CHK_ERRCNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_cnt <= '0;
      end else if (w_err_hit && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign o_err_cnt = r_err_cnt;
`else
   assign o_err_cnt = '0;
`endif

   assign o_lock = r_lock;
   assign o_err  = r_err;

endmodule

// File: tb/tb_prbs6_checker.sv
// Self-checking bench for prbs6_checker: directed scenarios plus randomized traffic.
module tb_prbs6_checker;

   localparam int unsigned LOCK_CNT    = 8;
   localparam int unsigned LOSS_THRESH = 4;
   localparam int unsigned WIN         = 32;
`ifdef PRBS6_CHK_ERRCNT_EN
   localparam bit ERRCNT_ON = 1'b1;
`else
   localparam bit ERRCNT_ON = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        din   = 1'b0;
   logic        vin   = 1'b0;
   logic        lock;
   logic        err;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   prbs6_checker #(
      .LOCK_CNT    (LOCK_CNT),
      .LOSS_THRESH (LOSS_THRESH),
      .WIN         (WIN)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_data    (din),
      .i_valid   (vin),
      .o_lock    (lock),
      .o_err     (err),
      .o_err_cnt (err_cnt)
   );

   int n_tests    = 0;
   int n_fail     = 0;
   int n_err_seen = 0;

   // Reference model: bit history kept as a queue, oldest first.
   logic mh[$];
   int   m_state;  // 0 seed, 1 verify, 2 locked
   int   m_seed, m_good, m_wbits, m_werr, m_errcnt;
   logic m_lock, m_err;

   // Clean generator stream: seed bits 0,0,0,0,0,1 then b[n] = b[n-5] ^ b[n-6].
   logic gq[$];
   int   gi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int k);
      return ERRCNT_ON ? 32'(k) : 32'd0;
   endfunction

   task automatic model_reset();
      mh = {};
      repeat (6) mh.push_back(1'b0);
      m_state  = 0;
      m_seed   = 0;
      m_good   = 0;
      m_wbits  = 0;
      m_werr   = 0;
      m_errcnt = 0;
      m_lock   = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic x);
      logic p;
      int   ones;
      m_err = 1'b0;
      if (v) begin
         p = mh[0] ^ mh[1];
         case (m_state)
            0: begin
               mh.push_back(x);
               void'(mh.pop_front());
               if (m_seed < 6) m_seed++;
               ones = 0;
               foreach (mh[i]) ones += int'(mh[i]);
               if (m_seed == 6 && ones != 0) begin
                  m_state = 1;
                  m_good  = 0;
               end
            end
            1: begin
               mh.push_back(x);
               void'(mh.pop_front());
               if (x == p) begin
                  m_good++;
                  if (m_good == LOCK_CNT) begin
                     m_state = 2;
                     m_lock  = 1'b1;
                     m_wbits = 0;
                     m_werr  = 0;
                  end
               end else begin
                  m_state = 0;
                  m_seed  = 0;
                  m_good  = 0;
               end
            end
            default: begin
               mh.push_back(p);
               void'(mh.pop_front());
               m_wbits++;
               if (x != p) begin
                  m_err = 1'b1;
                  m_werr++;
                  if (m_errcnt < 65535) m_errcnt++;
               end
               if (m_werr >= LOSS_THRESH) begin
                  m_state = 0;
                  m_lock  = 1'b0;
                  m_seed  = 0;
                  m_good  = 0;
                  m_wbits = 0;
                  m_werr  = 0;
               end else if (m_wbits == WIN) begin
                  m_wbits = 0;
                  m_werr  = 0;
               end
            end
         endcase
      end
   endtask

   task automatic gen_restart();
      gq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      gi = 0;
   endtask

   task automatic gen_bit(output logic b);
      if (gi >= 6) begin
         b = gq[gi-5] ^ gq[gi-6];
         gq.push_back(b);
      end else begin
         b = gq[gi];
      end
      gi++;
   endtask

   task automatic step(input logic v, input logic x);
      vin = v;
      din = x;
      @(posedge clk);
      model_step(v, x);
      #1;
      if (err === 1'b1) n_err_seen++;
      chk("lock", 32'(lock), 32'(m_lock));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), exp_cnt(m_errcnt));
   endtask

   task automatic send_gen(input logic flip);
      logic b;
      gen_bit(b);
      step(1'b1, b ^ flip);
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #2;
      chk("areset_lock", 32'(lock), 32'd0);
      chk("areset_err", 32'(err), 32'd0);
      chk("areset_cnt", 32'(err_cnt), 32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int   mode;
      logic v;
      logic b;
      model_reset();
      #3;
      chk("reset_lock", 32'(lock), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Clean stream: lock after exactly 14 valid bits.
      gen_restart();
      repeat (13) send_gen(1'b0);
      chk("lock_pre14", 32'(lock), 32'd0);
      send_gen(1'b0);
      chk("lock_at14", 32'(lock), 32'd1);

      // Single flipped bit at locked bit 20; flywheel keeps later bits clean.
      for (int i = 1; i <= 960; i++) begin
         send_gen(i == 20);
         if (i == 19) chk("no_err_clean", 32'(n_err_seen), 32'd0);
      end
      chk("single_pulses", 32'(n_err_seen), 32'd1);
      chk("single_lock", 32'(lock), 32'd1);
      chk("single_cnt", 32'(err_cnt), exp_cnt(1));

      // Four errors in one window: loss of lock, then relock in 14 bits.
      for (int i = 1; i <= 7; i++) begin
         send_gen(i % 2 == 1);
         if (i == 6) chk("loss_hold", 32'(lock), 32'd1);
      end
      chk("loss_lock", 32'(lock), 32'd0);
      chk("loss_pulses", 32'(n_err_seen), 32'd5);
      repeat (13) send_gen(1'b0);
      chk("relock_pre", 32'(lock), 32'd0);
      send_gen(1'b0);
      chk("relock", 32'(lock), 32'd1);
      chk("loss_cnt", 32'(err_cnt), exp_cnt(5));

      // Window boundary: 3+1 straddling keeps lock; 4 ending on bit 32 loses it.
      for (int i = 1; i <= 96; i++) begin
         send_gen((i >= 30 && i <= 33) || (i >= 93 && i <= 96));
         if (i == 64) chk("win_straddle", 32'(lock), 32'd1);
         if (i == 95) chk("win_pre_last", 32'(lock), 32'd1);
      end
      chk("win_last_bit", 32'(lock), 32'd0);
      chk("win_cnt", 32'(err_cnt), exp_cnt(13));

      // Asynchronous reset while locked.
      repeat (14) send_gen(1'b0);
      chk("lock_before_rst", 32'(lock), 32'd1);
      async_reset();

      // All-zero input holds off lock; clean stream then locks in 14 bits.
      repeat (20) step(1'b1, 1'b0);
      chk("zeros_nolock", 32'(lock), 32'd0);
      gen_restart();
      repeat (13) send_gen(1'b0);
      chk("zeros_pre", 32'(lock), 32'd0);
      send_gen(1'b0);
      chk("zeros_lock", 32'(lock), 32'd1);

      // VALID 1-of-3 with reset mid-VERIFY; lock counts valid bits only.
      async_reset();
      gen_restart();
      repeat (9) begin
         step(1'b0, 1'($urandom));
         step(1'b0, 1'($urandom));
         send_gen(1'b0);
      end
      async_reset();
      gen_restart();
      for (int i = 1; i <= 14; i++) begin
         step(1'b0, 1'($urandom));
         step(1'b0, 1'($urandom));
         if (i == 14) chk("sparse_pre", 32'(lock), 32'd0);
         send_gen(1'b0);
      end
      chk("sparse_lock", 32'(lock), 32'd1);

      // Randomized traffic: clean, noisy and garbage segments with gaps.
      for (int c = 0; c < 20; c++) begin
         mode = int'($urandom_range(2));
         for (int k = 0; k < 200; k++) begin
            v = ($urandom_range(3) != 0);
            if (!v) begin
               step(1'b0, 1'($urandom));
            end else if (mode == 1) begin
               step(1'b1, 1'($urandom));
            end else begin
               gen_bit(b);
               step(1'b1, b ^ ($urandom_range(mode == 0 ? 63 : 5) == 0));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
